temp_monitor: RTL and testbench
===============================

TEMP_MONITOR -- requirements
Module: temp_monitor

Interface
REQ-001 Parameter PERIOD_CYC, default 125000000: clk cycles between measurement starts (1 s at 125 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 112500000: clk cycles allowed from end of kick to t_done; legal only when TIMEOUT_CYC < PERIOD_CYC - RST_CYC.
REQ-003 clk  in  1  system clock, 125 MHz.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 t_done  in  1  one-cycle result strobe from the 1-wire temperature reader (its done output).
REQ-006 t_data  in  16  raw sensor word (its T_data output), signed two's complement, 1/16 degC per LSB.
REQ-007 t_hi  in  16  signed alarm threshold, same scale as t_data.
REQ-008 t_hyst  in  8  unsigned alarm hysteresis, same scale.
REQ-009 sens_rst  out  1  active-high restart to the 1-wire reader (drives its rst).
REQ-010 t_avg  out  16  signed 4-sample moving average.
REQ-011 avg_valid  out  1  one-cycle strobe on every t_avg update.
REQ-012 alarm  out  1  over-temperature level with hysteresis.
REQ-013 fault  out  1  sensor-fault level.
REQ-014 err_cnt  out  8  total rejected and timed-out measurements; saturates at 255.

Function
REQ-015 FSM states: KICK, WAIT, CHECK, IDLE; reset state is KICK.
REQ-016 KICK: sens_rst=1 for exactly RST_CYC=16 cycles, then go to WAIT with the timeout counter cleared.
REQ-017 WAIT: t_done=1 captures t_data and goes to CHECK; timeout counter reaching TIMEOUT_CYC logs an error and goes to IDLE; if both occur in the same cycle, t_done wins.
REQ-018 CHECK (1 cycle): t_data in [-880, 2000] (-55..+125 degC) is valid and goes to the averager; otherwise log an error; go to IDLE.
REQ-019 Free-running period counter wraps at PERIOD_CYC-1 and emits a tick; the tick moves IDLE to KICK; a tick in any other state is dropped.
REQ-020 Period counter restarts from 0 on every entry to KICK.
REQ-021 t_done outside WAIT is ignored: no capture, no error.
REQ-022 Averager: 4-entry shift window with 18-bit signed sum; t_avg = sum arithmetic-shifted right by 2 (floor).
REQ-023 First valid sample after reset preloads all 4 entries, so t_avg equals that sample.
REQ-024 t_avg and avg_valid update one cycle after CHECK accepts a sample; latency from t_done to avg_valid is 2 cycles.
REQ-025 Alarm is evaluated on the cycle after avg_valid: set when t_avg > t_hi; clear when t_avg < t_hi - t_hyst, computed in 17-bit signed; otherwise hold.
REQ-026 Error log: err_cnt increments (saturating) and a consecutive-error counter increments.
REQ-027 fault sets when the consecutive-error count reaches 3; a valid sample clears the consecutive count and fault in the same cycle avg_valid rises.
REQ-028 Errors never change t_avg or alarm.

Reset
REQ-029 While rst_n=0: sens_rst=1; t_avg=0, avg_valid=0, alarm=0, fault=0, err_cnt=0; window empty (preload pending); all counters 0; state KICK.
REQ-030 The first kick starts on the first clk edge after rst_n rises.
REQ-031 Reset asserted mid-operation aborts any capture; the next valid sample after release preloads again.

Structure
REQ-032 Package temp_pkg holds the state enum, T_MIN_RAW=-880, T_MAX_RAW=2000, RST_CYC=16, FAULT_N=3.
REQ-033 Sub-module temp_avg4 (window, sum, preload, avg_valid); FSM, timers, alarm and fault logic stay in temp_monitor.

Verification (PERIOD_CYC=2000, TIMEOUT_CYC=1500 on bench)
REQ-034 Reset release, t_done with t_data=0x0190 (25 degC) after 100 cycles -> sens_rst high exactly 16 cycles; avg_valid 2 cycles after t_done; t_avg=0x0190.
REQ-035 Valid samples 0x0190, 0x0190, 0x0190, 0x0210 -> t_avg=0x01B0 after the 4th; every subsequent kick falls on the period tick.
REQ-036 t_hi=0x0200, t_hyst=0x20, averages 0x0201 / 0x01F0 / 0x01DF -> alarm 1 / 1 / 0.
REQ-037 No t_done for 3 periods -> err_cnt=3; fault rises at the 3rd timeout; t_avg unchanged; one valid sample then clears fault.
REQ-038 Corner cases:
  - t_data=0xFC90 (-55 degC) -> accepted.
  - t_data=0x07D1 -> rejected, err_cnt+1.
  - t_done coinciding with timeout -> accepted.
  - t_done during IDLE -> ignored.
  - 300 errors -> err_cnt holds at 255.
  - rst_n pulse mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature monitor.
// Holds the sequencer state encoding, the sensor's legal raw range,
// the reader restart length and the consecutive-error fault threshold.
package temp_pkg;

  typedef enum logic [1:0] {
    KICK  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam int RST_CYC = 16;
  localparam int FAULT_N = 3;

  // Raw scale is 1/16 degC per LSB: -55 degC .. +125 degC.
  localparam logic signed [15:0] T_MIN_RAW = -16'sd880;
  localparam logic signed [15:0] T_MAX_RAW = 16'sd2000;

  function automatic logic in_range(input logic signed [15:0] t);
    return (t >= T_MIN_RAW) && (t <= T_MAX_RAW);
  endfunction

endpackage

// File: rtl/temp_monitor_if.sv
// Link between the monitor and the 1-wire temperature reader.
// Ports: t_done (result strobe), t_data (raw signed word), sens_rst (reader restart).
// master = reader side, slave = monitor side; no backpressure, results are strobed.
interface temp_monitor_if;
  logic        t_done;
  logic [15:0] t_data;
  logic        sens_rst;

  modport master (output t_done, output t_data, input sens_rst);
  modport slave  (input t_done, input t_data, output sens_rst);
endinterface

// File: rtl/temp_avg4.sv
// 4-sample moving average of accepted temperature samples.
// Latency: avg/avg_valid register one cycle after push; no backpressure.
// Ports: clk, rst_n, push + sample in; avg (floor of sum/4) and avg_valid strobe out.
module temp_avg4 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic signed [15:0] sample,
  output logic signed [15:0] avg,
  output logic               avg_valid
);

  // win[0] is the newest entry, win[3] the oldest.
  logic [3:0][15:0]   win;
  logic signed [17:0] sum;
  logic signed [17:0] sum_nxt;
  logic signed [17:0] s_ext;
  logic signed [17:0] old_ext;
  logic               empty;

  assign s_ext   = {{2{sample[15]}}, sample};
  assign old_ext = {{2{win[3][15]}}, win[3]};

  // The first sample fills the whole window so the average starts at that
  // sample instead of ramping up from zero.
  always_comb begin
    sum_nxt = sum + s_ext - old_ext;
    if (empty) sum_nxt = {sample, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      sum       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      empty     <= 1'b1;
    end else begin
      avg_valid <= push;
      if (push) begin
        sum   <= sum_nxt;
        // Dropping the two LSBs of a two's complement sum is floor(sum/4).
        avg   <= sum_nxt[17:2];
        empty <= 1'b0;
        if (empty) win <= {4{sample}};
        else       win <= {win[2:0], sample};
      end
    end
  end

endmodule

// File: rtl/temp_monitor.sv
// Periodic temperature sequencer: restarts the 1-wire reader, waits for a result,
// range-checks it, averages it and raises over-temperature alarm / sensor fault.
// Latency: t_done to avg_valid 2 cycles, alarm one cycle later; no backpressure.
// Ports: clk, rst_n, sens (reader link), t_hi/t_hyst thresholds;
//        t_avg, avg_valid, alarm, fault, err_cnt status out.
module temp_monitor
  import temp_pkg::*;
#(
  parameter int PERIOD_CYC  = 125000000,
  parameter int TIMEOUT_CYC = 112500000
) (
  input  logic               clk,
  input  logic               rst_n,
  temp_monitor_if.slave      sens,
  input  logic signed [15:0] t_hi,
  input  logic        [7:0]  t_hyst,
  output logic signed [15:0] t_avg,
  output logic               avg_valid,
  output logic               alarm,
  output logic               fault,
  output logic        [7:0]  err_cnt
);

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t             state, state_nxt;
  logic [PW-1:0]      per_cnt;
  logic [TW-1:0]      to_cnt;
  logic [3:0]         rst_cnt;
  logic [1:0]         cons_cnt;
  logic signed [15:0] t_cap;
  logic               tick;
  logic               to_hit;
  logic               push;
  logic               err;
  logic signed [16:0] clr_thr;
  logic signed [16:0] avg_ext;

  assign tick   = (per_cnt == PW'(PERIOD_CYC - 1));
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));

  assign sens.sens_rst = (state == KICK);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err       = 1'b0;
    case (state)
      KICK:  if (rst_cnt == 4'(RST_CYC - 1)) state_nxt = WAIT;
      // A result arriving on the last allowed cycle still counts.
      WAIT: begin
        if (sens.t_done) begin
          state_nxt = CHECK;
        end else if (to_hit) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (in_range(t_cap)) push = 1'b1;
        else                 err  = 1'b1;
        state_nxt = IDLE;
      end
      // Ticks seen outside IDLE are dropped; the next period picks up.
      IDLE:  if (tick) state_nxt = KICK;
      default: state_nxt = KICK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= KICK;
      per_cnt  <= '0;
      to_cnt   <= '0;
      rst_cnt  <= '0;
      cons_cnt <= '0;
      t_cap    <= '0;
      fault    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;

      // Each kick re-phases the period so measurements stay aligned to it.
      if (tick || (state_nxt == KICK && state != KICK)) per_cnt <= '0;
      else                                               per_cnt <= per_cnt + 1'b1;

      rst_cnt <= (state == KICK) ? rst_cnt + 1'b1 : '0;
      to_cnt  <= (state == WAIT) ? to_cnt + 1'b1 : '0;

      if (state == WAIT && sens.t_done) t_cap <= sens.t_data;

      if (err) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        if (cons_cnt != 2'(FAULT_N)) cons_cnt <= cons_cnt + 1'b1;
        if (cons_cnt >= 2'(FAULT_N - 1)) fault <= 1'b1;
      end else if (push) begin
        // Cleared on the same edge that raises avg_valid.
        cons_cnt <= '0;
        fault    <= 1'b0;
      end
    end
  end

  temp_avg4 u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .sample    (t_cap),
    .avg       (t_avg),
    .avg_valid (avg_valid)
  );

  // Clear threshold in 17 bits so t_hi - t_hyst cannot wrap near -32768.
  assign clr_thr = {t_hi[15], t_hi} - {9'd0, t_hyst};
  assign avg_ext = {t_avg[15], t_avg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (avg_valid) begin
      if (t_avg > t_hi)           alarm <= 1'b1;
      else if (avg_ext < clr_thr) alarm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_temp_monitor.sv
// Directed bench for temp_monitor with hand-computed expected values.
// Main instance: PERIOD_CYC=2000, TIMEOUT_CYC=1500; a second fast instance
// (PERIOD_CYC=40, TIMEOUT_CYC=20) never sees t_done and drives err_cnt into saturation.
module tb_temp_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic [15:0] t_hi;
  logic [7:0]  t_hyst;
  logic [15:0] t_avg, t_avg2;
  logic        avg_valid, avg_valid2;
  logic        alarm, alarm2;
  logic        fault, fault2;
  logic [7:0]  err_cnt, err_cnt2;

  always #5 clk = ~clk;

  temp_monitor_if mif ();
  temp_monitor_if mif2 ();

  temp_monitor #(.PERIOD_CYC(2000), .TIMEOUT_CYC(1500)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sens      (mif.slave),
    .t_hi      (t_hi),
    .t_hyst    (t_hyst),
    .t_avg     (t_avg),
    .avg_valid (avg_valid),
    .alarm     (alarm),
    .fault     (fault),
    .err_cnt   (err_cnt)
  );

  temp_monitor #(.PERIOD_CYC(40), .TIMEOUT_CYC(20)) dut_sat (
    .clk       (clk),
    .rst_n     (rst2_n),
    .sens      (mif2.slave),
    .t_hi      (t_hi),
    .t_hyst    (t_hyst),
    .t_avg     (t_avg2),
    .avg_valid (avg_valid2),
    .alarm     (alarm2),
    .fault     (fault2),
    .err_cnt   (err_cnt2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int last_kick = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the first negedge of WAIT; checks kick length and kick spacing.
  task automatic wait_kick_end();
    int n;
    int hi;
    n  = 0;
    hi = 0;
    while (!mif.sens_rst && n < 4000) begin @(negedge clk); n++; end
    if (last_kick >= 0) check("kick_period", cyc - last_kick, 2000);
    last_kick = cyc;
    while (mif.sens_rst && n < 4000) begin @(negedge clk); n++; hi++; end
    check("kick_wait_bound", n < 4000, 1);
    check("kick_len", hi, 16);
  endtask

  // One measurement: t_done after dly WAIT cycles; returns 2 cycles after t_done.
  task automatic meas(input logic [15:0] d, input int dly);
    wait_kick_end();
    repeat (dly) @(negedge clk);
    mif.t_done = 1'b1;
    mif.t_data = d;
    @(negedge clk);
    mif.t_done = 1'b0;
    mif.t_data = 16'h0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_sens_rst"},  mif.sens_rst, 1'b1);
    check({pfx, "_t_avg"},     t_avg, 16'h0000);
    check({pfx, "_avg_valid"}, avg_valid, 1'b0);
    check({pfx, "_alarm"},     alarm, 1'b0);
    check({pfx, "_fault"},     fault, 1'b0);
    check({pfx, "_err_cnt"},   err_cnt, 8'd0);
  endtask

  initial begin
    logic seen;
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    mif.t_done  = 1'b0;
    mif.t_data  = 16'h0;
    mif2.t_done = 1'b0;
    mif2.t_data = 16'h0;
    t_hi        = 16'h7FFF;
    t_hyst      = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // First sample after reset preloads the window.
    rst_n = 1'b1;
    meas(16'h0190, 84);
    check("first_valid", avg_valid, 1'b1);
    check("first_avg",   t_avg, 16'h0190);
    @(negedge clk);
    check("valid_strobe", avg_valid, 1'b0);

    meas(16'h0190, 10);
    check("avg_2", t_avg, 16'h0190);
    meas(16'h0190, 10);
    meas(16'h0210, 10);
    check("avg_4", t_avg, 16'h01B0);

    // Window 0x210,0x190,0x190,0x190 + (-880) drops 400: sum 448 -> 112.
    meas(16'hFC90, 5);
    check("min_valid", avg_valid, 1'b1);
    check("min_avg",   t_avg, 16'h0070);
    check("min_err",   err_cnt, 8'd0);

    meas(16'h07D1, 5);
    check("over_valid", avg_valid, 1'b0);
    check("over_err",   err_cnt, 8'd1);
    check("over_avg",   t_avg, 16'h0070);

    // 448 + 2000 - 400 = 2048 -> 512.
    meas(16'h07D0, 5);
    check("max_valid", avg_valid, 1'b1);
    check("max_avg",   t_avg, 16'h0200);

    // t_done while IDLE must do nothing.
    @(negedge clk);
    mif.t_done = 1'b1;
    mif.t_data = 16'h0100;
    @(negedge clk);
    mif.t_done = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | avg_valid; end
    check("idle_done_valid", seen, 1'b0);
    check("idle_done_err",   err_cnt, 8'd1);
    check("idle_done_avg",   t_avg, 16'h0200);

    // t_done on the timeout cycle wins: 2048 + 16 - 400 = 1664 -> 416.
    meas(16'h0010, 1499);
    check("edge_valid", avg_valid, 1'b1);
    check("edge_avg",   t_avg, 16'h01A0);
    check("edge_err",   err_cnt, 8'd1);

    // One cycle later it is a timeout and the t_done lands in IDLE.
    meas(16'h0010, 1500);
    check("late_valid", avg_valid, 1'b0);
    check("late_err",   err_cnt, 8'd2);
    check("late_avg",   t_avg, 16'h01A0);

    // 1664 + 16 - 528 = 1152 -> 288; also clears the consecutive count.
    meas(16'h0010, 5);
    check("pre_to_avg", t_avg, 16'h0120);

    for (int i = 0; i < 3; i++) begin
      wait_kick_end();
      repeat (1499) @(negedge clk);
      check("to_err_before",   err_cnt, 8'(2 + i));
      check("to_fault_before", fault, 1'b0);
      @(negedge clk);
      check("to_err_after",    err_cnt, 8'(3 + i));
      check("to_fault_after",  fault, (i == 2) ? 1'b1 : 1'b0);
      check("to_avg_hold",     t_avg, 16'h0120);
    end

    // 1152 + 16 - (-880) = 2048 -> 512; fault clears with avg_valid.
    meas(16'h0010, 5);
    check("recover_valid", avg_valid, 1'b1);
    check("recover_fault", fault, 1'b0);
    check("recover_avg",   t_avg, 16'h0200);

    // Reset pulse mid-WAIT: outputs return to reset values immediately.
    t_hi   = 16'h0200;
    t_hyst = 8'h20;
    wait_kick_end();
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    last_kick = -1;

    // Alarm: set above 0x200, hold down to 0x1E0, clear below 0x1E0.
    meas(16'h0201, 5);
    check("alm1_avg",  t_avg, 16'h0201);
    check("alm1_early", alarm, 1'b0);
    @(negedge clk);
    check("alm1", alarm, 1'b1);
    // 2052 + 445 - 513 = 1984 -> 496.
    meas(16'h01BD, 5);
    check("alm2_avg", t_avg, 16'h01F0);
    @(negedge clk);
    check("alm2", alarm, 1'b1);
    // 1984 + 445 - 513 = 1916 -> 479.
    meas(16'h01BD, 5);
    check("alm3_avg", t_avg, 16'h01DF);
    @(negedge clk);
    check("alm3", alarm, 1'b0);
    check("alm_err", err_cnt, 8'd0);

    // Fast instance: one timeout at cycle 36 + 40k after release.
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (4010) @(negedge clk);
    check("sat_mid_err",   err_cnt2, 8'd100);
    check("sat_mid_fault", fault2, 1'b1);
    repeat (8090) @(negedge clk);
    check("sat_err",       err_cnt2, 8'd255);
    check("sat_avg",       t_avg2, 16'h0000);
    check("sat_valid",     avg_valid2, 1'b0);
    check("sat_alarm",     alarm2, 1'b0);
    check("sat_sens_rst",  mif2.sens_rst, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
